// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, constants and the hex-to-segment decoder for the scanned display.
package seg_scan_pkg;
  typedef logic [0:6] seg_t;
  typedef logic [1:0] digit_idx_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam logic [0:3] AN_OFF = 4'hF;
  function automatic seg_t hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction
endpackage

// File: rtl/seg_scan_display_timer.sv
// seg_scan_timer: refresh prescaler, digit index, per-slot guard flag and frame-wrap strobe.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int GUARD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output digit_idx_t idx_o,
  output logic       guard_o,
  output logic       wrap_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  digit_idx_t idx_q, idx_d;
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    idx_d = &cnt_q ? idx_q + 2'd1 : idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
  assign idx_o   = idx_q;
  assign guard_o = cnt_q < DIV_W'(GUARD);
  // Last cycle of digit 3: the next edge starts a new frame.
  assign wrap_o  = &cnt_q && &idx_q;
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: 4-digit multiplexed active-low hex display with tear-free frame commit.
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_value,
  input  logic        i_load,
  input  logic        i_blank_lz,
  input  logic [3:0]  i_dp_mask,
  output logic [0:6]  seg,
  output logic [0:3]  an,
  output logic        dp,
  output logic        o_frame
);
  logic [15:0] pending_q, pending_d, shown_q, shown_d, upper;
  seg_t seg_d;
  logic [0:3] an_d;
  logic dp_d, lz_blank;
  digit_idx_t idx;
  logic guard, wrap;
  seg_scan_timer #(.DIV_W(DIV_W), .GUARD(GUARD)) u_timer (
    .clk    (clk),
    .rst_n  (i_reset_n),
    .idx_o  (idx),
    .guard_o(guard),
    .wrap_o (wrap)
  );
  always_comb begin
    pending_d = i_load ? i_value : pending_q;
    shown_d   = wrap ? pending_d : shown_q;
    upper     = shown_q >> {idx, 2'b00};
    lz_blank  = i_blank_lz && idx != 2'd0 && upper == 16'h0;
    an_d      = AN_OFF;
    an_d[idx] = guard;
    seg_d     = (guard || lz_blank) ? SEG_BLANK : hex_to_seg(upper[3:0]);
    dp_d      = guard | ~i_dp_mask[idx];
  end
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pending_q <= '0;
      shown_q   <= '0;
      seg       <= SEG_BLANK;
      an        <= AN_OFF;
      dp        <= 1'b1;
      o_frame   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      shown_q   <= shown_d;
      seg       <= seg_d;
      an        <= an_d;
      dp        <= dp_d;
      o_frame   <= wrap;
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: randomized and directed checks of the scanned display against a time-based model.
module tb_seg_scan_display;
  logic        clk = 0;
  logic        i_reset_n = 0;
  logic [15:0] i_value = 0;
  logic        i_load = 0;
  logic        i_blank_lz = 0;
  logic [3:0]  i_dp_mask = 0;
  logic [0:6]  seg;
  logic [0:3]  an;
  logic        dp, o_frame;
  int checks = 0, errors = 0;

  seg_scan_display #(.DIV_W(3), .GUARD(1)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_value(i_value), .i_load(i_load),
    .i_blank_lz(i_blank_lz), .i_dp_mask(i_dp_mask),
    .seg(seg), .an(an), .dp(dp), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  localparam logic [0:6] SEG_TAB [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000,
    7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference: n counts clock edges since reset; slot = n/8, digit = slot%4, guard when n%8==0.
  int n = 0, m_cnt, m_idx;
  logic [15:0] pend_m = 0, shown_m = 0, m_up;
  logic [0:6] exp_seg = 7'h7F;
  logic [0:3] exp_an = 4'hF;
  logic exp_dp = 1, exp_frame = 0;
  always @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      n = 0; pend_m = 0; shown_m = 0;
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1; exp_frame = 0;
    end else begin
      m_cnt = n % 8;
      m_idx = (n / 8) % 4;
      m_up = shown_m >> (4 * m_idx);
      exp_seg = (m_cnt == 0 || (i_blank_lz && m_idx > 0 && m_up == 0)) ? 7'h7F : SEG_TAB[m_up[3:0]];
      exp_an = 4'hF;
      if (m_cnt != 0) exp_an[m_idx] = 1'b0;
      exp_dp = (m_cnt == 0) ? 1'b1 : ~i_dp_mask[m_idx];
      exp_frame = (n % 32 == 31);
      if (n % 32 == 31) shown_m = i_load ? i_value : pend_m;
      if (i_load) pend_m = i_value;
      n++;
    end
  end

  logic [0:6] got [4];
  int lows [4];
  int multi, mm;

  task automatic wait_frame();
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (o_frame === 1'b1) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL frame_timeout got no o_frame within 100 cycles, required one");
    end
  endtask

  // Collects one 32-cycle frame starting at the current negedge (the o_frame cycle).
  task automatic scan_frame();
    multi = 0; mm = 0;
    for (int k = 0; k < 4; k++) begin lows[k] = 0; got[k] = 7'hXX; end
    for (int i = 0; i < 32; i++) begin
      int cnt = 0;
      if (i > 0) @(negedge clk);
      for (int k = 0; k < 4; k++) if (an[k] === 1'b0) begin lows[k]++; got[k] = seg; cnt++; end
      if (cnt > 1) multi++;
      if ({seg, an, dp, o_frame} !== {exp_seg, exp_an, exp_dp, exp_frame}) mm++;
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    i_value = v; i_load = 1;
    @(negedge clk);
    i_load = 0;
  endtask

  task automatic test_reset();
    logic [0:3] want = 4'hF;
    i_reset_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp f", an); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
    checks++; if (o_frame !== 1'b0) begin errors++; $display("FAIL reset_frame got %b exp 0", o_frame); end
    i_reset_n = 1;
    @(negedge clk);
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL first_guard_an got %h exp f", an); end
    @(negedge clk);
    want[0] = 1'b0;
    checks++; if (an !== want) begin errors++; $display("FAIL first_digit_an got %b exp %b", an, want); end
    checks++; if (seg !== 7'b0000001) begin errors++; $display("FAIL first_digit_seg got %b exp 0000001", seg); end
  endtask

  task automatic test_load_frame();
    pulse_load(16'h1A2F);
    wait_frame();
    scan_frame();
    checks++; if (got[0] !== SEG_TAB[15]) begin errors++; $display("FAIL load_d0 got %b exp %b", got[0], SEG_TAB[15]); end
    checks++; if (got[1] !== SEG_TAB[2]) begin errors++; $display("FAIL load_d1 got %b exp %b", got[1], SEG_TAB[2]); end
    checks++; if (got[2] !== SEG_TAB[10]) begin errors++; $display("FAIL load_d2 got %b exp %b", got[2], SEG_TAB[10]); end
    checks++; if (got[3] !== SEG_TAB[1]) begin errors++; $display("FAIL load_d3 got %b exp %b", got[3], SEG_TAB[1]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (lows[k] != 7) begin errors++; $display("FAIL anode_time k=%0d got %0d exp 7", k, lows[k]); end
    end
    checks++; if (multi != 0) begin errors++; $display("FAIL one_anode got %0d multi cycles exp 0", multi); end
    checks++; if (mm != 0) begin errors++; $display("FAIL load_model got %0d mismatches exp 0", mm); end
  endtask

  task automatic test_tearing();
    logic [0:6] g2 = 7'hXX, g3 = 7'hXX;
    wait_frame();
    repeat (10) @(negedge clk);
    pulse_load(16'h1234);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an[2] === 1'b0) g2 = seg;
      if (an[3] === 1'b0) g3 = seg;
    end
    checks++; if (g2 !== SEG_TAB[10]) begin errors++; $display("FAIL tear_d2 got %b exp %b", g2, SEG_TAB[10]); end
    checks++; if (g3 !== SEG_TAB[1]) begin errors++; $display("FAIL tear_d3 got %b exp %b", g3, SEG_TAB[1]); end
    wait_frame();
    scan_frame();
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== SEG_TAB[4 - k]) begin errors++; $display("FAIL tear_new k=%0d got %b exp %b", k, got[k], SEG_TAB[4 - k]); end
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL tear_model got %0d mismatches exp 0", mm); end
  endtask

  task automatic test_commit_load();
    logic [3:0] want [4] = '{4'hF, 4'hE, 4'hE, 4'hB};
    wait_frame();
    repeat (31) @(negedge clk);
    i_value = 16'hBEEF; i_load = 1;
    @(negedge clk);
    i_load = 0;
    checks++; if (o_frame !== 1'b1) begin errors++; $display("FAIL commit_frame got %b exp 1", o_frame); end
    scan_frame();
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== SEG_TAB[want[k]]) begin errors++; $display("FAIL commit_d%0d got %b exp %b", k, got[k], SEG_TAB[want[k]]); end
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL commit_model got %0d mismatches exp 0", mm); end
  endtask

  task automatic test_lz();
    i_blank_lz = 1;
    pulse_load(16'h0040);
    wait_frame();
    scan_frame();
    checks++; if (got[3] !== 7'h7F) begin errors++; $display("FAIL lz_d3 got %b exp 1111111", got[3]); end
    checks++; if (got[2] !== 7'h7F) begin errors++; $display("FAIL lz_d2 got %b exp 1111111", got[2]); end
    checks++; if (got[1] !== SEG_TAB[4]) begin errors++; $display("FAIL lz_d1 got %b exp %b", got[1], SEG_TAB[4]); end
    checks++; if (got[0] !== SEG_TAB[0]) begin errors++; $display("FAIL lz_d0 got %b exp %b", got[0], SEG_TAB[0]); end
    checks++; if (lows[3] != 7) begin errors++; $display("FAIL lz_anode3 got %0d exp 7", lows[3]); end
    pulse_load(16'h0000);
    wait_frame();
    scan_frame();
    for (int k = 1; k < 4; k++) begin
      checks++; if (got[k] !== 7'h7F) begin errors++; $display("FAIL lz0_d%0d got %b exp 1111111", k, got[k]); end
    end
    checks++; if (got[0] !== SEG_TAB[0]) begin errors++; $display("FAIL lz0_d0 got %b exp %b", got[0], SEG_TAB[0]); end
    checks++; if (mm != 0) begin errors++; $display("FAIL lz_model got %0d mismatches exp 0", mm); end
    i_blank_lz = 0;
  endtask

  task automatic test_dp_reset();
    int dpl [4] = '{0, 0, 0, 0};
    int stray = 0;
    i_dp_mask = 4'b0101;
    wait_frame();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (dp === 1'b0) begin
        if (an === 4'hF) stray++;
        for (int k = 0; k < 4; k++) if (an[k] === 1'b0) dpl[k]++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (dpl[k] != (i_dp_mask[k] ? 7 : 0)) begin errors++; $display("FAIL dp_d%0d got %0d exp %0d", k, dpl[k], i_dp_mask[k] ? 7 : 0); end
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL dp_guard got %0d exp 0", stray); end
    repeat (3) @(negedge clk);
    i_reset_n = 0;
    #1;
    checks++; if ({seg, an, dp, o_frame} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL async_reset got seg=%b an=%b dp=%b fr=%b", seg, an, dp, o_frame);
    end
    @(negedge clk);
    i_reset_n = 1;
    @(negedge clk);
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL restart_guard got %b exp 1111", an); end
    @(negedge clk);
    checks++; if (an[0] !== 1'b0 || seg !== SEG_TAB[0]) begin errors++; $display("FAIL restart_d0 got an=%b seg=%b", an, seg); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL rnd_seg t=%0t got %b exp %b", $time, seg, exp_seg); end
      checks++; if (an !== exp_an) begin errors++; $display("FAIL rnd_an t=%0t got %b exp %b", $time, an, exp_an); end
      checks++; if (dp !== exp_dp) begin errors++; $display("FAIL rnd_dp t=%0t got %b exp %b", $time, dp, exp_dp); end
      checks++; if (o_frame !== exp_frame) begin errors++; $display("FAIL rnd_frame t=%0t got %b exp %b", $time, o_frame, exp_frame); end
      i_load = ($urandom_range(0, 6) == 0);
      i_value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 40) == 0) i_blank_lz = ~i_blank_lz;
      if ($urandom_range(0, 40) == 0) i_dp_mask = 4'($urandom);
    end
    i_load = 0;
  endtask

  initial begin
    test_reset();
    test_load_frame();
    test_tearing();
    test_commit_load();
    test_lz();
    test_dp_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
